// File: rtl/ova_crop_gray.sv
// Crop a window out of an RGB565 camera stream and emit it as 8-bit gray.
// Two-stage pixel pipeline, frame-level IDLE/ACTIVE/DROP control.
module ova_crop_gray #(
  parameter int CROP_X0 = 16,
  parameter int CROP_Y0 = 16,
  parameter int CROP_W  = 224,
  parameter int CROP_H  = 224
) (
  input  logic        i_pclk,
  input  logic        rst_n,
  input  logic [15:0] i_data,
  input  logic        i_data_vld,
  input  logic        i_href,
  input  logic        i_vsync,
  input  logic        i_fifo_full,
  output logic [7:0]  o_gray,
  output logic        o_gray_vld,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_frame_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_e;

  typedef struct packed {
    logic        vld;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
  } s1_t;

  typedef struct packed {
    logic        vld;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] sum;
  } s2_t;

  localparam logic [10:0] X_LO = 11'(CROP_X0);
  localparam logic [10:0] Y_LO = 11'(CROP_Y0);
  localparam logic [10:0] W_11 = 11'(CROP_W);
  localparam logic [10:0] H_11 = 11'(CROP_H);
  localparam logic [10:0] W_M1 = 11'(CROP_W - 1);
  localparam logic [10:0] H_M1 = 11'(CROP_H - 1);

  state_e      state_q, state_d;
  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  line_q, line_d;
  logic        frame_err_q, frame_err_d;
  s1_t         s1_q, s1_d;
  s2_t         s2_q, s2_d;

  logic        acc;
  logic        vs_fall;
  logic        vs_rise;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_win;
  logic        tag_sof;
  logic        tag_eol;
  logic        tag_eof;
  logic        emit;
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;

  assign acc     = i_href & i_data_vld;
  assign vs_fall = vsync_q & ~i_vsync;
  assign vs_rise = ~vsync_q & i_vsync;

  // Offsets wrap to large values left of / above the window,
  // so one unsigned compare per axis covers both bounds.
  assign dx      = {1'b0, col_q} - X_LO;
  assign dy      = {1'b0, line_q} - Y_LO;
  assign in_win  = (dx < W_11) && (dy < H_11);
  assign tag_sof = (dx == 11'd0) && (dy == 11'd0);
  assign tag_eol = (dx == W_M1);
  assign tag_eof = tag_eol && (dy == H_M1);

  assign r8 = {i_data[15:11], i_data[15:13]};
  assign g8 = {i_data[10:5], i_data[10:9]};
  assign b8 = {i_data[4:0], i_data[4:2]};

  always_comb begin
    href_d  = i_href;
    vsync_d = i_vsync;
    col_d   = col_q;
    line_d  = line_q;
    if (!i_href) begin
      col_d = '0;
    end else if (acc) begin
      col_d = col_q + 10'd1;
    end
    if (i_vsync) begin
      line_d = '0;
    end else if (href_q && !i_href) begin
      line_d = line_q + 10'd1;
    end
  end

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (vs_fall) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_d = IDLE;
        end else if (acc && in_win) begin
          if (i_fifo_full)  state_d = DROP;
          else if (tag_eof) state_d = IDLE;
        end
      end
      DROP: begin
        if (vs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    emit        = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == ACTIVE && !vs_rise && acc && in_win) begin
      if (i_fifo_full) frame_err_d = 1'b1;
      else             emit        = 1'b1;
    end
  end

  always_comb begin
    s1_d = '0;
    if (emit) begin
      s1_d.vld = 1'b1;
      s1_d.sof = tag_sof;
      s1_d.eol = tag_eol;
      s1_d.eof = tag_eof;
      s1_d.pr  = 16'd77 * {8'd0, r8};
      s1_d.pg  = 16'd150 * {8'd0, g8};
      s1_d.pb  = 16'd29 * {8'd0, b8};
    end
  end

  always_comb begin
    s2_d     = '0;
    s2_d.vld = s1_q.vld;
    s2_d.sof = s1_q.sof & s1_q.vld;
    s2_d.eol = s1_q.eol & s1_q.vld;
    s2_d.eof = s1_q.eof & s1_q.vld;
    s2_d.sum = s1_q.pr + s1_q.pg + s1_q.pb;
  end

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      col_q       <= '0;
      line_q      <= '0;
      frame_err_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
    end else begin
      href_q      <= href_d;
      vsync_q     <= vsync_d;
      col_q       <= col_d;
      line_q      <= line_d;
      frame_err_q <= frame_err_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

  assign o_gray      = s2_q.sum[15:8];
  assign o_gray_vld  = s2_q.vld;
  assign o_sof       = s2_q.sof;
  assign o_eol       = s2_q.eol;
  assign o_eof       = s2_q.eof;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_ova_crop_gray.sv
// Bench for ova_crop_gray: three crop geometries on one shared stream,
// compared cycle by cycle against a frame-coordinate reference model.
module tb_ova_crop_gray;

  localparam int NI = 3;
  localparam int FW = 8;
  localparam int FH = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] data = '0;
  logic vld = 1'b0;
  logic href = 1'b0;
  logic vsync = 1'b0;
  logic full = 1'b0;

  logic [NI-1:0][7:0] gray;
  logic [NI-1:0] gv, sof, eol, eof, err;

  always #5 clk = ~clk;

  ova_crop_gray #(.CROP_X0(2), .CROP_Y0(1), .CROP_W(4), .CROP_H(3)) u_a (
    .i_pclk(clk), .rst_n(rst_n), .i_data(data), .i_data_vld(vld),
    .i_href(href), .i_vsync(vsync), .i_fifo_full(full),
    .o_gray(gray[0]), .o_gray_vld(gv[0]), .o_sof(sof[0]),
    .o_eol(eol[0]), .o_eof(eof[0]), .o_frame_err(err[0]));

  ova_crop_gray #(.CROP_X0(0), .CROP_Y0(0), .CROP_W(2), .CROP_H(2)) u_b (
    .i_pclk(clk), .rst_n(rst_n), .i_data(data), .i_data_vld(vld),
    .i_href(href), .i_vsync(vsync), .i_fifo_full(full),
    .o_gray(gray[1]), .o_gray_vld(gv[1]), .o_sof(sof[1]),
    .o_eol(eol[1]), .o_eof(eof[1]), .o_frame_err(err[1]));

  ova_crop_gray #(.CROP_X0(5), .CROP_Y0(1), .CROP_W(1), .CROP_H(1)) u_c (
    .i_pclk(clk), .rst_n(rst_n), .i_data(data), .i_data_vld(vld),
    .i_href(href), .i_vsync(vsync), .i_fifo_full(full),
    .o_gray(gray[2]), .o_gray_vld(gv[2]), .o_sof(sof[2]),
    .o_eol(eol[2]), .o_eof(eof[2]), .o_frame_err(err[2]));

  typedef struct packed {
    logic       vld;
    logic [7:0] g;
    logic       sof;
    logic       eol;
    logic       eof;
    logic       err;
  } exp_t;

  int   wx0 [NI] = '{2, 0, 5};
  int   wy0 [NI] = '{1, 0, 1};
  int   ww  [NI] = '{4, 2, 1};
  int   wh  [NI] = '{3, 2, 1};

  exp_t expq [NI][8];
  bit   act  [NI];
  bit   pv;
  int   t;
  int   total;
  int   bad;
  int   nv   [NI];
  int   nsof [NI];
  int   neol [NI];
  int   neof [NI];
  int   nerr [NI];
  logic [7:0] gq_b [$];
  logic [15:0] dtab [4] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h001F};
  logic [7:0]  gtab [4] = '{8'hFF, 8'h00, 8'h4C, 8'h1C};

  function automatic logic [7:0] gray_of(input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
  endfunction

  task automatic model_clear();
    pv = 1'b0;
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0;
      for (int k = 0; k < 8; k++) expq[i][k] = '0;
    end
  endtask

  task automatic clr_cnt();
    gq_b.delete();
    for (int i = 0; i < NI; i++) begin
      nv[i] = 0; nsof[i] = 0; neol[i] = 0;
      neof[i] = 0; nerr[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic model_step(input bit h, input bit v, input bit vs,
                            input bit f, input logic [15:0] d,
                            input int x, input int y);
    bit fall, rise, inw;
    exp_t e;
    fall = pv && !vs;
    rise = !pv && vs;
    for (int i = 0; i < NI; i++) begin
      inw = x >= wx0[i] && x < wx0[i] + ww[i] &&
            y >= wy0[i] && y < wy0[i] + wh[i];
      if (act[i]) begin
        if (rise) begin
          act[i] = 1'b0;
        end else if (h && v && inw) begin
          if (f) begin
            act[i] = 1'b0;
            expq[i][(t + 1) % 8].err = 1'b1;
          end else begin
            e     = '0;
            e.vld = 1'b1;
            e.g   = gray_of(d);
            e.sof = x == wx0[i] && y == wy0[i];
            e.eol = x == wx0[i] + ww[i] - 1;
            e.eof = e.eol && y == wy0[i] + wh[i] - 1;
            expq[i][(t + 2) % 8] = e;
            if (e.eof) act[i] = 1'b0;
          end
        end
      end else if (fall) begin
        act[i] = 1'b1;
      end
    end
    pv = vs;
  endtask

  task automatic check_outs();
    exp_t e;
    logic [12:0] o, x;
    for (int i = 0; i < NI; i++) begin
      e = expq[i][t % 8];
      expq[i][t % 8] = '0;
      o = {gv[i], gv[i] ? gray[i] : 8'h00,
           sof[i], eol[i], eof[i], err[i]};
      x = {e.vld, e.vld ? e.g : 8'h00,
           e.sof, e.eol, e.eof, e.err};
      total++;
      assert (o === x) else begin
        bad++;
        $error("FAIL out%0d t=%0d observed=%h expected=%h", i, t, o, x);
      end
      if (gv[i])  nv[i]++;
      if (sof[i]) nsof[i]++;
      if (eol[i]) neol[i]++;
      if (eof[i]) neof[i]++;
      if (err[i]) nerr[i]++;
      if (i == 1 && gv[i]) gq_b.push_back(gray[i]);
    end
  endtask

  task automatic tick(input bit h, input bit v, input bit vs,
                      input bit f, input logic [15:0] d,
                      input int x, input int y);
    href  = h;
    vld   = v;
    vsync = vs;
    full  = f;
    data  = d;
    if (rst_n) model_step(h, v, vs, f, d, x, y);
    else       model_clear();
    @(negedge clk);
    t++;
    check_outs();
  endtask

  task automatic mid_reset();
    logic [55:0] z;
    #3 rst_n = 1'b0;
    #1;
    z = {gray, gv, sof, eol, eof, err};
    total++;
    assert (z === 56'd0) else begin
      bad++;
      $error("FAIL reset_async observed=%h expected=0", z);
    end
    model_clear();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 16'(($urandom)), -1, -1);
    rst_n = 1'b1;
  endtask

  task automatic frame(input int fx, input int fy, input int cut,
                       input bit dir, input int rl, input bit novs);
    logic [15:0] d;
    bit f;
    clr_cnt();
    if (!novs) begin
      repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, -1, -1);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, -1, -1);
    end
    for (int y = 0; y < FH; y++) begin
      if (y == cut) break;
      for (int x = 0; x < FW; x++) begin
        repeat ($urandom_range(0, 1))
          tick(1'b1, 1'b0, 1'b0, 1'($urandom), 16'($urandom), -1, -1);
        d = 16'($urandom);
        if (dir && x < 2 && y < 2) d = dtab[y * 2 + x];
        f = (x == fx && y == fy);
        tick(1'b1, 1'b1, 1'b0, f, d, x, y);
        if (y == rl && x == 3) mid_reset();
      end
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, -1, -1);
    end
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, -1, -1);
  endtask

  initial begin
    logic [55:0] z;
    total = 0;
    bad   = 0;
    t     = 0;
    model_clear();
    clr_cnt();
    repeat (2) @(negedge clk);
    z = {gray, gv, sof, eol, eof, err};
    total++;
    assert (z === 56'd0) else begin
      bad++;
      $error("FAIL reset_state observed=%h expected=0", z);
    end
    rst_n = 1'b1;

    // frame already running at reset release: ignored
    frame(-1, -1, -1, 1'b0, -1, 1'b1);
    chk("ignored_a", nv[0], 0);
    chk("ignored_b", nv[1], 0);

    // known pixel values and tag placement
    frame(-1, -1, -1, 1'b1, -1, 1'b0);
    chk("dir_cnt_b", gq_b.size(), 4);
    for (int k = 0; k < 4 && k < gq_b.size(); k++)
      chk("dir_gray_b", int'(gq_b[k]), int'(gtab[k]));
    chk("dir_eol_b", neol[1], 2);
    chk("win_cnt_a", nv[0], 12);
    chk("win_eol_a", neol[0], 3);
    chk("win_sof_a", nsof[0], 1);
    chk("win_eof_a", neof[0], 1);
    chk("w1_sof_c", nsof[2], 1);
    chk("w1_eof_c", neof[2], 1);

    // overflow on crop pixel (3,2)
    frame(3, 2, -1, 1'b0, -1, 1'b0);
    chk("ovf_err_a", nerr[0], 1);
    chk("ovf_cnt_a", nv[0], 5);
    chk("ovf_eof_a", neof[0], 0);
    chk("ovf_cnt_b", nv[1], 4);
    frame(-1, -1, -1, 1'b0, -1, 1'b0);
    chk("after_ovf_a", nv[0], 12);

    // truncated frame, then a normal one
    frame(-1, -1, 2, 1'b0, -1, 1'b0);
    chk("trunc_cnt_a", nv[0], 4);
    chk("trunc_eof_a", neof[0], 0);
    frame(-1, -1, -1, 1'b0, -1, 1'b0);
    chk("after_trunc_sof", nsof[0], 1);
    chk("after_trunc_cnt", nv[0], 12);

    // reset mid-line, then recovery
    frame(-1, -1, -1, 1'b0, 2, 1'b0);
    chk("rst_eof_a", neof[0], 0);
    frame(-1, -1, -1, 1'b0, -1, 1'b0);
    chk("after_rst_a", nv[0], 12);

    for (int n = 0; n < 4; n++) begin
      frame(-1, -1, -1, 1'b0, -1, 1'b0);
      chk("rnd_cnt_a", nv[0], 12);
      chk("rnd_cnt_b", nv[1], 4);
      chk("rnd_cnt_c", nv[2], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ova_crop_gray.md
OVA_CROP_GRAY -- requirements
Module: ova_crop_gray

Interface
REQ-001 Parameter CROP_X0, default 16, first pixel column of the crop window (0-based).
REQ-002 Parameter CROP_Y0, default 16, first line of the crop window (0-based).
REQ-003 Parameter CROP_W, default 224, crop window width in pixels, range 1..1023.
REQ-004 Parameter CROP_H, default 224, crop window height in lines, range 1..1023.
REQ-005 i_pclk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_data  in  16  RGB565 pixel from the capture stage: [15:11] R, [10:5] G, [4:0] B.
REQ-008 i_data_vld  in  1  pixel strobe from the capture stage.
REQ-009 i_href  in  1  camera line-active qualifier.
REQ-010 i_vsync  in  1  camera frame sync; high means vertical blanking.
REQ-011 i_fifo_full  in  1  downstream FIFO full flag.
REQ-012 o_gray  out  8  grayscale pixel.
REQ-013 o_gray_vld  out  1  o_gray valid; also the FIFO write enable.
REQ-014 o_sof  out  1  high with the first crop pixel of a frame.
REQ-015 o_eol  out  1  high with the last pixel of each crop line.
REQ-016 o_eof  out  1  high with the last pixel of the crop window.
REQ-017 o_frame_err  out  1  one-cycle pulse when a frame is aborted on overflow.

Function
REQ-018 A pixel is accepted on any cycle in which i_href=1 and i_data_vld=1; no other cycle carries a pixel.
REQ-019 Column counter (10 bit): cleared while i_href=0; increments by 1 on each accepted pixel; the first pixel of a line is column 0.
REQ-020 Line counter (10 bit): cleared while i_vsync=1; increments by 1 on each i_href 1->0 transition (detected on a registered copy of i_href).
REQ-021 A pixel is in-window iff CROP_X0 <= col < CROP_X0+CROP_W and CROP_Y0 <= line < CROP_Y0+CROP_H.
REQ-022 The FSM has three states: IDLE, ACTIVE and DROP.
REQ-023 IDLE -> ACTIVE on an i_vsync 1->0 edge.
REQ-024 ACTIVE -> IDLE when a pixel tagged o_eof is emitted, or when i_vsync rises.
REQ-025 ACTIVE -> DROP when an in-window pixel is accepted while i_fifo_full=1; o_frame_err pulses for exactly 1 cycle on that transition.
REQ-026 DROP -> IDLE when i_vsync rises; no outputs are emitted while in DROP or IDLE.
REQ-027 Gray conversion:
- Expand the channels: r8={R,R[4:2]}, g8={G,G[5:4]}, b8={B,B[4:2]}.
- sum = 77*r8 + 150*g8 + 29*b8, using 16-bit unsigned arithmetic.
- o_gray = sum[15:8]; the result never overflows, since the maximum sum is 65280.
REQ-028 Pipeline stage 1 registers the three products and the tags; stage 2 registers the sum and drives the outputs.
REQ-029 o_gray_vld asserts exactly 2 i_pclk cycles after the accepted in-window pixel; the pipeline cannot stall.
REQ-030 Tags (o_sof, o_eol, o_eof) are computed from the counters at acceptance and travel with the pixel through the pipeline.
REQ-031 o_sof, o_eol and o_eof are only ever high while o_gray_vld=1.
REQ-032 Pixels already in the pipeline when the FSM enters DROP are still emitted.
REQ-033 Pixels already in the pipeline when i_vsync rises mid-frame are still emitted; no o_eof is generated for a truncated frame.
REQ-034 If CROP_W=1, o_sof, o_eol and o_eof may coincide, and all are high on that single pixel.

Reset
REQ-035 While rst_n=0, all outputs, counters, pipeline registers and the registered i_href are 0, and the FSM is in IDLE.
REQ-036 Reset is asserted asynchronously and released on an i_pclk edge.
REQ-037 After reset release the block waits for the next i_vsync 1->0 edge before accepting any pixel; a frame already in progress is ignored.
REQ-038 Reset asserted mid-frame clears the in-flight pipeline; no partial output follows reset release.

Verification
REQ-039 Pixel value: CROP_X0=CROP_Y0=0, CROP_W=CROP_H=2, pixels 0xFFFF, 0x0000, 0xF800, 0x001F -> o_gray 0xFF, 0x00, 0x4C, 0x1C, each 2 cycles after acceptance; o_sof on the first, o_eol on the 2nd and 4th, o_eof on the 4th.
REQ-040 Window: default parameters, 640x480 frame, valid every other cycle -> exactly 50176 o_gray_vld pulses, 224 o_eol, one o_sof and one o_eof.
REQ-041 Overflow: assert i_fifo_full at crop pixel 100 -> one o_frame_err pulse; at most 2 further o_gray_vld (pipeline drain); nothing more until the next frame, which runs normally.
REQ-042 Truncation: raise i_vsync after crop line 10 -> FSM enters IDLE, no o_eof, and the next frame starts with o_sof.
REQ-043 Reset: assert rst_n=0 mid-line -> all outputs 0 within the same cycle; after release, no output until a vsync falling edge.
